mem_responder: RTL and testbench

- Memory-side responder for the tagged BUS_LOAD/BUS_STORE protocol issued by the instruction cache and its prefetcher.
- Accepts or rejects each request combinationally in the same cycle, returning a nonzero transaction tag on accept.
- Returns load data with the matching tag after a fixed latency, over a synthesizable word-addressed backing store.
- Used as the memory end in cache unit benches and as the synthesizable memory model in FPGA builds.

---
 rtl/mem_responder_pkg.sv | 22 ++
 rtl/mem_return_pipe.sv | 53 +++++
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the tagged memory responder.
// Bus commands, tag width and the tag-successor helper.
package mem_responder_pkg;

   localparam int XLEN = 32;
   localparam int MEM_TAG_W = 4;
   localparam logic [MEM_TAG_W-1:0] MEM_NO_TAG = 4'd0;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   // Tags cycle 1..15; 0 is reserved for "no tag"
   function automatic logic [MEM_TAG_W-1:0] tag_next(
      input logic [MEM_TAG_W-1:0] t
   );
      return (t == 4'd15) ? 4'd1 : t + 4'd1;
   endfunction

endpackage

// File: rtl/mem_return_pipe.sv
// Fixed-latency in-order load return pipeline (valid/tag/index).
// pre_* is the stage one cycle ahead of the output, used for the data read.
module mem_return_pipe
   import mem_responder_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int IDX_W   = 10
) (
   input  logic                 clock,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [MEM_TAG_W-1:0] in_tag,
   input  logic [IDX_W-1:0]     in_idx,
   output logic                 pre_valid,
   output logic [IDX_W-1:0]     pre_idx,
   output logic                 out_valid,
   output logic [MEM_TAG_W-1:0] out_tag
);

   logic [LATENCY-1:0]   vld_q;
   logic [MEM_TAG_W-1:0] tag_q [LATENCY];

   always_ff @(posedge clock) begin
      if (flush) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= in_valid;
         for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
   end

   assign out_valid = vld_q[LATENCY-1];
   assign out_tag   = tag_q[LATENCY-1];

   if (LATENCY == 1) begin : g_lat1
      assign pre_valid = in_valid;
      assign pre_idx   = in_idx;
   end else begin : g_latn
      logic [IDX_W-1:0] idx_q [LATENCY-1];
      always_ff @(posedge clock) begin
         idx_q[0] <= in_idx;
         for (int i = 1; i < LATENCY-1; i++) idx_q[i] <= idx_q[i-1];
      end
      assign pre_valid = vld_q[LATENCY-2];
      assign pre_idx   = idx_q[LATENCY-2];
   end

endmodule

// File: rtl/mem_responder.sv
// Tagged BUS_LOAD/BUS_STORE memory responder with fixed load latency.
// Define MEM_RESPONDER_STALL_EN to add LFSR-driven random load rejects.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int MEM_WORDS       = 1024,
   parameter int LATENCY         = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [1:0]           proc2mem_command,
   input  logic [XLEN-1:0]      proc2mem_addr,
   input  logic [63:0]          proc2mem_data,
   output logic [MEM_TAG_W-1:0] mem2proc_response,
   output logic [63:0]          mem2proc_data,
   output logic [MEM_TAG_W-1:0] mem2proc_tag
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [MEM_TAG_W-1:0] tag_q, tag_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [63:0]          data_q, data_d;
   logic [63:0]          mem_q [MEM_WORDS];

   logic             ld_acc, st_acc, stall;
   logic [IDX_W-1:0] idx;
   logic             pre_valid, out_valid, ret_v;
   logic [IDX_W-1:0] pre_idx;
   logic [MEM_TAG_W-1:0] out_tag;
   logic             unused_addr;

   assign idx = proc2mem_addr[3 +: IDX_W];
   assign unused_addr = ^{proc2mem_addr[2:0],
                          proc2mem_addr[XLEN-1:3+IDX_W]};

`ifdef MEM_RESPONDER_STALL_EN
   logic [7:0] lfsr_q, lfsr_d;
   assign lfsr_d = {lfsr_q[6:0],
                    lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign stall  = (lfsr_q[1:0] == 2'b00);
   always_ff @(posedge clock) begin
      if (reset) lfsr_q <= 8'hA5;
      else       lfsr_q <= lfsr_d;
   end
`else
   assign stall = 1'b0;
`endif

   // Returns are masked while reset is high so flushed loads never surface
   assign ret_v = out_valid & ~reset;
   assign mem2proc_tag  = ret_v ? out_tag : MEM_NO_TAG;
   assign mem2proc_data = data_q;

   always_comb begin
      ld_acc = 1'b0;
      st_acc = 1'b0;
      if (!reset) begin
         ld_acc = (proc2mem_command == BUS_LOAD) &&
                  (cnt_q < CNT_W'(MAX_OUTSTANDING)) && !stall;
         st_acc = (proc2mem_command == BUS_STORE);
      end
      mem2proc_response = (ld_acc || st_acc) ? tag_q : MEM_NO_TAG;
      tag_d = (ld_acc || st_acc) ? tag_next(tag_q) : tag_q;
      case ({ld_acc, ret_v})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      data_d = data_q;
      // Forward a same-cycle store so the return sees every earlier store
      if (pre_valid) begin
         if (st_acc && (idx == pre_idx)) data_d = proc2mem_data;
         else                            data_d = mem_q[pre_idx];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tag_q  <= 4'd1;
         cnt_q  <= '0;
         data_q <= '0;
      end else begin
         tag_q  <= tag_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
      end
   end

   always_ff @(posedge clock) begin
      if (st_acc) mem_q[idx] <= proc2mem_data;
   end

   mem_return_pipe #(
      .LATENCY (LATENCY),
      .IDX_W   (IDX_W)
   ) u_pipe (
      .clock     (clock),
      .flush     (reset),
      .in_valid  (ld_acc),
      .in_tag    (tag_q),
      .in_idx    (idx),
      .pre_valid (pre_valid),
      .pre_idx   (pre_idx),
      .out_valid (out_valid),
      .out_tag   (out_tag)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder (LATENCY=4, MAX_OUTSTANDING=4).
// With MEM_RESPONDER_STALL_EN the bench checks rejects against a reference LFSR.
module tb_mem_responder;
   import mem_responder_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  cmd;
   logic [31:0] addr;
   logic [63:0] wdata;
   logic [3:0]  resp;
   logic [63:0] rdata;
   logic [3:0]  rtag;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   mem_responder #(
      .MEM_WORDS       (1024),
      .LATENCY         (4),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .proc2mem_command  (cmd),
      .proc2mem_addr     (addr),
      .proc2mem_data     (wdata),
      .mem2proc_response (resp),
      .mem2proc_data     (rdata),
      .mem2proc_tag      (rtag)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [63:0] wd;
      logic [3:0]  resp;
      logic [3:0]  tag;
      logic        chk;
      logic [63:0] dat;
   } vec_t;

   localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
   localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
   localparam logic [63:0] D0 = 64'hDEAD_BEEF_0000_0001;
   localparam logic [63:0] DE = 64'hAAAA_0000_0000_000E;
   localparam logic [63:0] DF = 64'hBBBB_0000_0000_000F;

   vec_t tv[$];

   function automatic vec_t mk(
      input logic r, input logic [1:0] c, input logic [31:0] a,
      input logic [63:0] w, input logic [3:0] rs, input logic [3:0] tg,
      input logic ck, input logic [63:0] d);
      vec_t v;
      v.rst = r; v.cmd = c; v.addr = a; v.wd = w;
      v.resp = rs; v.tag = tg; v.chk = ck; v.dat = d;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Inputs change just after posedge; outputs sampled at negedge
   task automatic drive(input logic r, input logic [1:0] c,
                        input logic [31:0] a, input logic [63:0] w);
      reset = r; cmd = c; addr = a; wdata = w;
      @(negedge clock);
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; cmd = 2'd0; addr = '0; wdata = '0;
      next_cycle();

`ifndef MEM_RESPONDER_STALL_EN
      tv.push_back(mk(1, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(1, 2, 'h40,  DA, 0, 0, 1, 0));
      tv.push_back(mk(0, 2, 'h40,  DA, 1, 0, 0, 0));
      tv.push_back(mk(0, 2, 'h48,  DB, 2, 0, 0, 0));
      tv.push_back(mk(1, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 1, 'h40,  0,  1, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 1, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 1, 1, DA));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 1, DA));
      tv.push_back(mk(1, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 2, 'h10,  D0, 1, 0, 0, 0));
      tv.push_back(mk(0, 1, 'h14,  0,  2, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 2, 1, D0));
      tv.push_back(mk(0, 1, 'h48,  0,  3, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 2, 'h48,  DE, 4, 0, 0, 0));
      tv.push_back(mk(0, 2, 'h48,  DF, 5, 3, 1, DE));
      tv.push_back(mk(0, 1, 'h48,  0,  6, 0, 1, DE));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 1, DE));
      tv.push_back(mk(0, 0, 0,     0,  0, 6, 1, DF));
      tv.push_back(mk(1, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 1, 'h00,  0,  1, 0, 0, 0));
      tv.push_back(mk(0, 1, 'h08,  0,  2, 0, 0, 0));
      tv.push_back(mk(0, 1, 'h10,  0,  3, 0, 0, 0));
      tv.push_back(mk(0, 1, 'h18,  0,  4, 0, 0, 0));
      tv.push_back(mk(0, 1, 'h20,  0,  0, 1, 0, 0));
      tv.push_back(mk(0, 1, 'h20,  0,  5, 2, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 3, 1, D0));
      tv.push_back(mk(0, 0, 0,     0,  0, 4, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 5, 0, 0));
      tv.push_back(mk(1, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 1, 'h00,  0,  1, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(1, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 1, 'h40,  0,  1, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0,     0,  0, 0, 0, 0));
      tv.push_back(mk(0, 3, 'h40,  0,  0, 1, 1, DA));

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].rst, tv[i].cmd, tv[i].addr, tv[i].wd);
         check($sformatf("row%0d resp", i), 64'(resp), 64'(tv[i].resp));
         check($sformatf("row%0d tag", i), 64'(rtag), 64'(tv[i].tag));
         if (tv[i].chk)
            check($sformatf("row%0d data", i), rdata, tv[i].dat);
         next_cycle();
      end

      // Tag wrap over 16 accepted stores
      drive(1'b1, 2'd0, '0, '0);
      next_cycle();
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 2'd2, 32'(i * 8), 64'(i));
         check($sformatf("wrap%0d resp", i), 64'(resp),
               64'((i % 15) + 1));
         next_cycle();
      end
      drive(1'b0, 2'd0, '0, '0);
      check("wrap idle resp", 64'(resp), 64'd0);
      next_cycle();
`else
      begin
         logic [7:0] lfsr;
         logic [3:0] tg;
         int         cnt;
         logic       acc_v [64];
         logic [3:0] acc_t [64];
         logic       ok, ret;
         logic [3:0] exp_r, exp_t;
         drive(1'b1, 2'd0, '0, '0);
         next_cycle();
         lfsr = 8'hA5; tg = 4'd1; cnt = 0;
         for (int i = 0; i < 64; i++) begin
            ret   = (i >= 4) && acc_v[i-4];
            exp_t = ret ? acc_t[i-4] : 4'd0;
            acc_v[i] = 1'b0;
            acc_t[i] = 4'd0;
            if (i % 4 == 3) begin
               exp_r = tg;
               tg = (tg == 4'd15) ? 4'd1 : tg + 4'd1;
               drive(1'b0, 2'd2, 32'(i * 8), 64'(i));
            end else begin
               ok = (lfsr[1:0] != 2'b00) && (cnt < 4);
               exp_r = ok ? tg : 4'd0;
               if (ok) begin
                  acc_v[i] = 1'b1;
                  acc_t[i] = tg;
                  tg = (tg == 4'd15) ? 4'd1 : tg + 4'd1;
               end
               drive(1'b0, 2'd1, 32'(i * 8), '0);
            end
            check($sformatf("stall%0d resp", i), 64'(resp), 64'(exp_r));
            check($sformatf("stall%0d tag", i), 64'(rtag), 64'(exp_t));
            cnt = cnt + (acc_v[i] ? 1 : 0) - (ret ? 1 : 0);
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            next_cycle();
         end
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
